// File: rtl/internet_mux_arbiter.sv
// internet_mux_arbiter
// Four-source round-robin arbiter and multiplexer for the shared 4-bit link.
// A granted source owns the link for a burst. Every release passes through
// one IDLE cycle before the next grant.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   LibReq/FDReq/SchoolReq/RibsReq  level-sensitive link requests
//   LibData/FDData/SchoolData/RibsData  4-bit source payloads
//   Ready                           downstream accepts a beat this cycle
//   muxOutput                       link payload, zero unless Enable
//   Sel                             granted source (00 Lib .. 11 Ribs), held in IDLE
//   Enable                          link carries valid data
//   Grant                           one-hot grant (bit0 Lib .. bit3 Ribs)
//
// Build option
//   MUX_HOLD_LIMIT_EN  when defined, a grant also ends on its HOLD_MAX-th beat.
//
// State | meaning
// IDLE  | link idle, arbitrate among requests
// GRANT | Sel owns the link, count beats, wait for release
module internet_mux_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       LibReq,
  input  logic       FDReq,
  input  logic       SchoolReq,
  input  logic       RibsReq,
  input  logic [3:0] LibData,
  input  logic [3:0] FDData,
  input  logic [3:0] SchoolData,
  input  logic [3:0] RibsData,
  input  logic       Ready,
  output logic [3:0] muxOutput,
  output logic [1:0] Sel,
  output logic       Enable,
  output logic [3:0] Grant
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

`ifdef MUX_HOLD_LIMIT_EN
  localparam bit LimitEn = 1'b1;
`else
  // Without the limit the beat counter has no reader and folds away.
  localparam bit LimitEn = 1'b0;
`endif

  // Count value that the limiting beat starts from.
  localparam logic [3:0] HoldLast = 4'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] req;
  logic [1:0] cand;
  logic       found;
  logic       beat;

  assign req = {RibsReq, SchoolReq, FDReq, LibReq};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      last_q  <= 2'b11;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cand    = 2'b00;
    found   = 1'b0;
    beat    = 1'b0;
    case (state_q)
      IDLE: begin
        // Search starts just past the previous owner, so it is served last.
        for (int i = 1; i <= 4; i++) begin
          cand = last_q + 2'(i);
          if (!found && req[cand]) begin
            found = 1'b1;
            sel_d = cand;
          end
        end
        if (found) begin
          state_d = GRANT;
          cnt_d   = 4'd0;
        end
      end
      GRANT: begin
        beat = Ready;
        if (beat && (cnt_q != 4'hF)) begin
          cnt_d = cnt_q + 4'd1;
        end
        if (!req[sel_q] || (LimitEn && beat && (cnt_q == HoldLast))) begin
          state_d = IDLE;
          last_d  = sel_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Enable = (state_q == GRANT);
  assign Sel    = sel_q;
  assign Grant  = Enable ? (4'b0001 << sel_q) : 4'b0000;

  always_comb begin
    muxOutput = 4'b0000;
    if (Enable) begin
      case (sel_q)
        2'b00:   muxOutput = LibData;
        2'b01:   muxOutput = FDData;
        2'b10:   muxOutput = SchoolData;
        default: muxOutput = RibsData;
      endcase
    end
  end

endmodule

// File: tb/tb_internet_mux_arbiter.sv
// tb_internet_mux_arbiter
// Directed bench for internet_mux_arbiter. Inputs change 1 ns after the
// rising edge; outputs are checked there too, reflecting that edge.
module tb_internet_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_v = 4'b0000;
  logic [3:0] dat [4];
  logic       Ready = 1'b1;
  logic [3:0] muxOutput;
  logic [1:0] Sel;
  logic       Enable;
  logic [3:0] Grant;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  internet_mux_arbiter #(.HOLD_MAX(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .LibReq     (req_v[0]),
    .FDReq      (req_v[1]),
    .SchoolReq  (req_v[2]),
    .RibsReq    (req_v[3]),
    .LibData    (dat[0]),
    .FDData     (dat[1]),
    .SchoolData (dat[2]),
    .RibsData   (dat[3]),
    .Ready      (Ready),
    .muxOutput  (muxOutput),
    .Sel        (Sel),
    .Enable     (Enable),
    .Grant      (Grant)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_v = 4'b0000;
    Ready = 1'b1;
    dat[0] = 4'h1; dat[1] = 4'hA; dat[2] = 4'hC; dat[3] = 4'h7;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dat[0] = 4'h1; dat[1] = 4'hA; dat[2] = 4'hC; dat[3] = 4'h7;
    #1;
    tests_run++;
    if (Enable !== 1'b0 || Grant !== 4'b0000 || Sel !== 2'b00 || muxOutput !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_values: en=%b grant=%b sel=%b mux=%h, want 0/0000/00/0", Enable, Grant, Sel, muxOutput);
    end
    step();
    rst_n = 1'b1;
    req_v = 4'b0010;
    step();
    tests_run++;
    if (Enable !== 1'b1 || Sel !== 2'b01) begin
      tests_failed++;
      $display("FAIL reset_pre_grant: en=%b sel=%b, want 1/01", Enable, Sel);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (Enable !== 1'b0 || Grant !== 4'b0000 || muxOutput !== 4'h0 || Sel !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_async: en=%b grant=%b mux=%h sel=%b, want 0/0000/0/00", Enable, Grant, muxOutput, Sel);
    end
    step();
    req_v = 4'b1111;
    rst_n = 1'b1;
    step();
    tests_run++;
    if (Enable !== 1'b1 || Sel !== 2'b00 || Grant !== 4'b0001 || muxOutput !== 4'h1) begin
      tests_failed++;
      $display("FAIL reset_first_lib: en=%b sel=%b grant=%b mux=%h, want 1/00/0001/1", Enable, Sel, Grant, muxOutput);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_v = 4'b0010;
    step();
    tests_run++;
    if (Enable !== 1'b1 || Sel !== 2'b01 || Grant !== 4'b0010 || muxOutput !== 4'hA) begin
      tests_failed++;
      $display("FAIL single_grant: en=%b sel=%b grant=%b mux=%h, want 1/01/0010/a", Enable, Sel, Grant, muxOutput);
    end
    dat[1] = 4'h5;
    #1;
    tests_run++;
    if (muxOutput !== 4'h5) begin
      tests_failed++;
      $display("FAIL single_comb_data: mux=%h, want 5", muxOutput);
    end
    dat[1] = 4'hA;
    req_v = 4'b0000;
    step();
    tests_run++;
    if (Enable !== 1'b0 || muxOutput !== 4'h0 || Grant !== 4'b0000 || Sel !== 2'b01) begin
      tests_failed++;
      $display("FAIL single_release: en=%b mux=%h grant=%b sel=%b, want 0/0/0000/01", Enable, muxOutput, Grant, Sel);
    end
    step();
    tests_run++;
    if (Enable !== 1'b0 || muxOutput !== 4'h0) begin
      tests_failed++;
      $display("FAIL single_stays_idle: en=%b mux=%h, want 0/0", Enable, muxOutput);
    end
  endtask

`ifdef MUX_HOLD_LIMIT_EN
  task automatic test_fairness();
    logic [1:0] exp_sel;
    logic       exp_en;
    do_reset();
    req_v = 4'b1111;
    for (int k = 0; k < 40; k++) begin
      step();
      exp_en  = ((k % 5) != 4);
      exp_sel = 2'((k / 5) % 4);
      tests_run++;
      if (Enable !== exp_en || (exp_en && (Sel !== exp_sel || muxOutput !== dat[exp_sel]))) begin
        tests_failed++;
        $display("FAIL fairness_cycle%0d: en=%b sel=%b mux=%h, want en=%b sel=%b", k, Enable, Sel, muxOutput, exp_en, exp_sel);
      end
    end
  endtask
`else
  task automatic test_unlimited();
    int lib_cycles;
    do_reset();
    req_v = 4'b1001;
    lib_cycles = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (Enable === 1'b1 && Sel === 2'b00) lib_cycles++;
    end
    tests_run++;
    if (lib_cycles != 10) begin
      tests_failed++;
      $display("FAIL unlimited_lib_cycles: got %0d, want 10", lib_cycles);
    end
    req_v = 4'b1000;
    step();
    tests_run++;
    if (Enable !== 1'b0 || muxOutput !== 4'h0) begin
      tests_failed++;
      $display("FAIL unlimited_bubble: en=%b mux=%h, want 0/0", Enable, muxOutput);
    end
    step();
    tests_run++;
    if (Enable !== 1'b1 || Sel !== 2'b11 || Grant !== 4'b1000 || muxOutput !== 4'h7) begin
      tests_failed++;
      $display("FAIL unlimited_ribs: en=%b sel=%b grant=%b mux=%h, want 1/11/1000/7", Enable, Sel, Grant, muxOutput);
    end
  endtask
`endif

  task automatic test_backpressure();
    logic [6:0] r_pat;
    int         en_cycles;
    int         exp_cycles;
    do_reset();
    r_pat = 7'b1110001;
    req_v = 4'b0100;
    step();
    en_cycles = (Enable === 1'b1) ? 1 : 0;
    for (int j = 0; j < 7; j++) begin
      Ready = r_pat[j];
      step();
      if (Enable === 1'b1) begin
        en_cycles++;
        tests_run++;
        if (Sel !== 2'b10 || muxOutput !== 4'hC) begin
          tests_failed++;
          $display("FAIL backpressure_hold%0d: sel=%b mux=%h, want 10/c", j, Sel, muxOutput);
        end
      end
    end
`ifdef MUX_HOLD_LIMIT_EN
    exp_cycles = 7;
`else
    exp_cycles = 8;
`endif
    tests_run++;
    if (en_cycles != exp_cycles) begin
      tests_failed++;
      $display("FAIL backpressure_enable_cycles: got %0d, want %0d", en_cycles, exp_cycles);
    end
    Ready = 1'b1;
    req_v = 4'b0000;
    step();
    tests_run++;
    if (Enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_release: en=%b, want 0", Enable);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_sel;
    do_reset();
    req_v = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_sel = 2'(k % 4);
      step();
      tests_run++;
      if (Enable !== 1'b1 || Sel !== exp_sel || Grant !== (4'b0001 << exp_sel) || muxOutput !== dat[exp_sel]) begin
        tests_failed++;
        $display("FAIL rotation_grant%0d: en=%b sel=%b grant=%b mux=%h, want sel=%b", k, Enable, Sel, Grant, muxOutput, exp_sel);
      end
      req_v[exp_sel] = 1'b0;
      step();
      tests_run++;
      if (Enable !== 1'b0 || Grant !== 4'b0000 || muxOutput !== 4'h0) begin
        tests_failed++;
        $display("FAIL rotation_idle%0d: en=%b grant=%b mux=%h, want 0/0000/0", k, Enable, Grant, muxOutput);
      end
      req_v[exp_sel] = 1'b1;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req_v = 4'b1000;
    step();
    tests_run++;
    if (Sel !== 2'b11 || Enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_ribs_first: sel=%b en=%b, want 11/1", Sel, Enable);
    end
    req_v = 4'b0000;
    step();
    req_v = 4'b0101;
    step();
    tests_run++;
    if (Enable !== 1'b1 || Sel !== 2'b00 || Grant !== 4'b0001) begin
      tests_failed++;
      $display("FAIL wrap_lib: en=%b sel=%b grant=%b, want 1/00/0001", Enable, Sel, Grant);
    end
    req_v = 4'b0100;
    step();
    tests_run++;
    if (Enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_bubble: en=%b, want 0", Enable);
    end
    step();
    tests_run++;
    if (Enable !== 1'b1 || Sel !== 2'b10 || Grant !== 4'b0100 || muxOutput !== 4'hC) begin
      tests_failed++;
      $display("FAIL wrap_school: en=%b sel=%b grant=%b mux=%h, want 1/10/0100/c", Enable, Sel, Grant, muxOutput);
    end
  endtask

  task automatic test_release_priority();
    do_reset();
    req_v = 4'b0011;
    step();
    tests_run++;
    if (Sel !== 2'b00 || Enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL relprio_lib: sel=%b en=%b, want 00/1", Sel, Enable);
    end
    req_v = 4'b0010;
    step();
    req_v = 4'b0011;
    step();
    tests_run++;
    if (Enable !== 1'b1 || Sel !== 2'b01 || Grant !== 4'b0010) begin
      tests_failed++;
      $display("FAIL relprio_fd_wins: en=%b sel=%b grant=%b, want 1/01/0010", Enable, Sel, Grant);
    end
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef MUX_HOLD_LIMIT_EN
    test_fairness();
`else
    test_unlimited();
`endif
    test_backpressure();
    test_rotation();
    test_wrap();
    test_release_priority();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
